apb_master_bridge: RTL
======================

# apb_master_bridge

Command-driven APB initiator that drives the I2C core's APB register block from a simple host-side request interface. Host requests (read or write, 8-bit address, 8-bit data) are buffered in a small command FIFO. Each request is issued as a standard APB SETUP/ACCESS transfer, and each completed transfer returns a single-cycle response pulse carrying read data and an error flag. It sits between a processor/sequencer and the APB register slave that owns the prescale, address, command, transmit, status and receive registers.

## Interface
- DEPTH, 4: command FIFO entries; power of 2, ≥2.
- RD_LAT, 1: cycles after the completing ACCESS edge at which PRDATA is captured (0 or 1). The I2C register block registers PRDATA at the completing edge, so the default is 1.
- TIMEOUT, 16: ACCESS wait-cycle limit; only used with the timeout feature.
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host request valid.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  APB address; bits [7:5] select the slave register.
- cmd_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_write  out  1  direction of the completed transfer.
- rsp_rdata  out  8  captured read data; 0x00 for writes and aborts.
- rsp_err  out  1  transfer aborted by timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address.
- PWDATA  out  8  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  8  slave read data.

## Operation
- **FIFO**
  - Each entry is 17 bits {write, addr, wdata}.
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full.
  - Pop occurs on entry to SETUP.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- **FSM states**: IDLE, SETUP, ACCESS, RDWAIT.
- **IDLE**
  - PSELx=0, PENABLE=0.
  - If the FIFO is non-empty: pop, load PADDR/PWDATA/PWRITE, go to SETUP.
- **SETUP**
  - PSELx=1, PENABLE=0.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - PSELx=1, PENABLE=1; hold until PREADY is sampled high.
  - On completion, for a write or for a read with RD_LAT=0: capture PRDATA (reads), pulse the response, then go to SETUP with a pop if the FIFO is non-empty, else IDLE.
  - For a read with RD_LAT=1: go to RDWAIT.
- **RDWAIT**
  - PSELx=0, PENABLE=0.
  - Capture PRDATA at this edge, pulse the response, then go to the next state by the same rule as ACCESS.
- **Bus hold**: PADDR/PWDATA/PWRITE change only when a new command is loaded. They hold their last values in IDLE, so the slave's registered address decode stays stable.
- **Response registers**
  - rsp_* are registered. rsp_valid is high for exactly one cycle per command, in issue order.
  - rsp_rdata=0x00 for writes.
- **Simultaneous push and pop**: permitted when not full; occupancy is unchanged.
- **Reset (asynchronous)**
  - All outputs go to 0 immediately, except cmd_ready, which goes to 1.
  - FIFO emptied, FSM to IDLE.
  - A transfer in flight is dropped with no response.

## Timing
- Command pushed at edge E0:
  - PSELx=1 after E1 (SETUP).
  - PENABLE=1 after E2.
  - With zero wait states, PREADY is sampled at E3 and rsp_valid is high during the cycle after E3.
- Read latency:
  - RD_LAT=0: rsp_valid in the cycle after E3.
  - RD_LAT=1: rsp_valid in the cycle after E4.
- Back-to-back writes
  - Sustained throughput is 2 cycles per transfer.
  - PSELx stays high across transfers; PENABLE alternates 0/1.
- Wait states: each cycle with PREADY low in ACCESS adds one cycle.

## Configuration
- **APB_MASTER_TIMEOUT_EN defined**
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY low.
  - When it reaches TIMEOUT, the transfer is aborted: PSELx and PENABLE deassert, the response pulses with rsp_err=1 and rsp_rdata=0x00, and the FSM takes the normal next-state path.
  - PREADY high in the same cycle as the limit counts as a normal completion.
- **Undefined**
  - No counter exists; ACCESS waits indefinitely.
  - rsp_err is tied to 0.

## Test plan
- Write 0x5A to 0x20 (zero-wait slave) -> SETUP with PADDR=0x20, PWDATA=0x5A, PWRITE=1; one ACCESS cycle; rsp_valid 3 cycles after push with rsp_write=1, rsp_err=0.
- Read 0x60, RD_LAT=1, slave drives PRDATA=0x81 one cycle after the completing edge -> rsp_rdata=0x81 in the cycle after RDWAIT.
- Three writes pushed on consecutive cycles -> PSELx high continuously for 6 cycles, PENABLE toggling 0,1,0,1,0,1; three responses returned in order.
- PREADY held low, 5 pushes, DEPTH=4 -> cmd_ready=0 after the fifth push (1 in flight + 4 queued); release PREADY -> all 5 complete and cmd_ready returns to 1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=8, PREADY stuck low -> abort after 8 ACCESS cycles with rsp_err=1, rsp_rdata=0x00. Without the macro -> the FSM is still in ACCESS after 100 cycles.
- PRESET asserted mid-ACCESS -> PSELx=PENABLE=0 and busy=0 without waiting for PCLK; cmd_ready=1; no rsp_valid.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Command-FIFO-fed APB initiator: buffers host read/write requests and issues them as
// SETUP/ACCESS transfers, returning one registered response pulse per command.
// Optional macro APB_MASTER_TIMEOUT_EN adds an ACCESS wait-state limit with error response.
module apb_master_bridge #(
    parameter int DEPTH   = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_write,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       PSELx,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic       PREADY,
    input  logic [7:0] PRDATA,
    output logic [1:0] dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RD_LAT < 0 || RD_LAT > 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_master_bridge: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [16:0] head;
    logic        empty, full, push, pop;
    logic [7:0]  paddr_q, pwdata_q;
    logic        pwrite_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        done;
    logic [7:0]  done_rdata;

    // Full when pointers differ only in the wrap bit.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE  = 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rsp_err_q, rsp_err_d;
    logic          done_err;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        done        = 1'b0;
        done_rdata  = 8'h00;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        rsp_err_d   = rsp_err_q;
        done_err    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_ACCESS: begin
                if (PREADY) begin
                    if (pwrite_q || (RD_LAT == 0)) begin
                        done       = 1'b1;
                        done_rdata = pwrite_q ? 8'h00 : PRDATA;
                    end else begin
                        state_d = S_RDWAIT;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
`endif
                end
            end
            S_RDWAIT: begin
                done       = 1'b1;
                done_rdata = PRDATA;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion chains straight into the next SETUP so PSELx stays high.
        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = pwrite_q;
            rsp_rdata_d = done_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_d   = done_err;
`endif
            if (!empty) begin
                pop     = 1'b1;
                state_d = S_SETUP;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            paddr_q     <= 8'h00;
            pwdata_q    <= 8'h00;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                pwrite_q <= head[16];
                paddr_q  <= head[15:8];
                pwdata_q <= head[7:0];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            to_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready   = !full;
    assign busy        = !empty || (state_q != S_IDLE);
    assign PSELx       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign dbg_state_o = state_q;

endmodule
